// File: rtl/bp_mcore_looper.sv
// Hardware looper: hands out contiguous chunks of [GSTART, GEND) to requesting cores.
// A round-robin arbiter serialises all core accesses onto one register file.
module bp_mcore_looper #(
    parameter int num_core_p   = 4,
    parameter int addr_width_p = 40,
    parameter int data_width_p = 64
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_core_p-1:0]                req_v_i,
    output logic [num_core_p-1:0]                req_ready_o,
    input  logic [num_core_p-1:0]                req_w_i,
    input  logic [num_core_p*addr_width_p-1:0]   req_addr_i,
    input  logic [num_core_p*data_width_p-1:0]   req_data_i,
    output logic [num_core_p-1:0]                resp_v_o,
    input  logic [num_core_p-1:0]                resp_ready_i,
    output logic [num_core_p*data_width_p-1:0]   resp_data_o,
    output logic [num_core_p-1:0]                resp_err_o,
    output logic [1:0]                           dbg_state_o
);

    localparam int ptr_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam logic [addr_width_p-1:0] base_lp = addr_width_p'(64'h0050_0000);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                             state_q, state_d;
    logic                               enable_q, enable_d;
    logic [data_width_p-1:0]            gstart_q, gstart_d;
    logic [data_width_p-1:0]            gend_q, gend_d;
    logic [data_width_p-1:0]            next_q, next_d;
    logic [data_width_p-1:0]            asize_q, asize_d;
    logic [ptr_w_lp-1:0]                ptr_q;
    logic [num_core_p-1:0]              resp_v_q, resp_err_q;
    logic [num_core_p*data_width_p-1:0] resp_data_q;

    logic [num_core_p-1:0]   eligible;
    logic                    gnt_v;
    logic [ptr_w_lp-1:0]     gnt_idx;
    logic                    sel_w;
    logic [addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0] sel_data;
    logic [data_width_p-1:0] rdata;
    logic                    rerr;
    logic [data_width_p-1:0] remaining, asize_eff, chunk;

    // A port may be granted when its response slot is empty or drains on this same edge.
    always_comb begin : arb
        int cand;
        cand        = 0;
        eligible    = req_v_i & (~resp_v_q | resp_ready_i);
        gnt_v       = 1'b0;
        gnt_idx     = '0;
        req_ready_o = '0;
        for (int k = 0; k < num_core_p; k++) begin
            if (!gnt_v) begin
                cand = int'(ptr_q) + k;
                if (cand >= num_core_p) cand = cand - num_core_p;
                if (eligible[cand]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = ptr_w_lp'(cand);
                end
            end
        end
        if (gnt_v) req_ready_o[gnt_idx] = 1'b1;
    end

    assign sel_w    = req_w_i[gnt_idx];
    assign sel_addr = req_addr_i[gnt_idx*addr_width_p +: addr_width_p];
    assign sel_data = req_data_i[gnt_idx*data_width_p +: data_width_p];

    // GEND - NEXT bounds the step so NEXT never passes GEND and never wraps.
    assign remaining = gend_q - next_q;
    assign asize_eff = (asize_q == '0) ? data_width_p'(1) : asize_q;
    assign chunk     = (asize_eff < remaining) ? asize_eff : remaining;

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        gstart_d = gstart_q;
        gend_d   = gend_q;
        next_d   = next_q;
        asize_d  = asize_q;
        rdata    = '0;
        rerr     = 1'b0;
        if (gnt_v) begin
            if (sel_addr == base_lp) begin
                if (sel_w) begin
                    enable_d = sel_data[0];
                    if (sel_data[2]) begin
                        next_d = gstart_q;
                        if (!sel_data[0])            state_d = S_IDLE;
                        else if (gstart_q >= gend_q) state_d = S_DONE;
                        else                         state_d = S_RUN;
                    end else if (state_q == S_IDLE && sel_data[0]) begin
                        next_d  = gstart_q;
                        state_d = (gstart_q >= gend_q) ? S_DONE : S_RUN;
                    end else if (state_q != S_IDLE && !sel_data[0]) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    rdata = {{(data_width_p-2){1'b0}}, state_q == S_DONE, enable_q};
                end
            end else if (sel_addr == base_lp + addr_width_p'(8)) begin
                if (!sel_w)                 rdata    = gstart_q;
                else if (state_q == S_RUN)  rerr     = 1'b1;
                else                        gstart_d = sel_data;
            end else if (sel_addr == base_lp + addr_width_p'(16)) begin
                if (!sel_w)                 rdata  = gend_q;
                else if (state_q == S_RUN)  rerr   = 1'b1;
                else                        gend_d = sel_data;
            end else if (sel_addr == base_lp + addr_width_p'(24)) begin
                if (sel_w) begin
                    rerr = 1'b1;
                end else if (state_q == S_RUN) begin
                    rdata  = next_q;
                    next_d = next_q + chunk;
                    if (chunk == remaining) state_d = S_DONE;
                end else begin
                    rdata = gend_q;
                end
            end else if (sel_addr == base_lp + addr_width_p'(32)) begin
                if (!sel_w)                 rdata   = asize_q;
                else if (state_q == S_RUN)  rerr    = 1'b1;
                else                        asize_d = sel_data;
            end else begin
                rerr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            gstart_q    <= '0;
            gend_q      <= '0;
            next_q      <= '0;
            asize_q     <= data_width_p'(1);
            ptr_q       <= '0;
            resp_v_q    <= '0;
            resp_err_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            gstart_q <= gstart_d;
            gend_q   <= gend_d;
            next_q   <= next_d;
            asize_q  <= asize_d;
            if (gnt_v) begin
                ptr_q <= (int'(gnt_idx) == num_core_p - 1) ? '0 : gnt_idx + 1'b1;
            end
            for (int i = 0; i < num_core_p; i++) begin
                if (gnt_v && gnt_idx == ptr_w_lp'(i)) begin
                    resp_v_q[i]                                <= 1'b1;
                    resp_err_q[i]                              <= rerr;
                    resp_data_q[i*data_width_p +: data_width_p] <= rdata;
                end else if (resp_ready_i[i]) begin
                    resp_v_q[i] <= 1'b0;
                end
            end
        end
    end

    assign resp_v_o    = resp_v_q;
    assign resp_err_o  = resp_err_q;
    assign resp_data_o = resp_data_q;
    assign dbg_state_o = state_q;

endmodule
